// File: rtl/keypad_if.sv
// One-hot key interface between the matrix scanner (master) and its consumer.
// The scanner drives the column lines and receives the keypad rows.
interface keypad_if;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] onehot;
    logic        key_valid;
    logic        key_down;

    modport master (
        input  row_in,
        output col_out,
        output onehot,
        output key_valid,
        output key_down
    );

    modport slave (
        output row_in,
        input  col_out,
        input  onehot,
        input  key_valid,
        input  key_down
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column drive, row synchronizer, frame assembly and a
// press/release debounce FSM that holds the last accepted key as a one-hot code.
module keypad_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DB    = CW'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
    typedef enum logic [1:0] {EMPTY, SINGLE, MULTI} frame_cls_t;

    logic [3:0]    row_s1_q, row_s2_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    col_q;
    logic [15:0]   frame_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   cand_q, cand_d;
    logic [15:0]   onehot_q, onehot_d;
    logic          key_valid_q, key_valid_d;
    logic          key_down_q, key_down_d;

    logic          sample;
    logic          frame_end;
    logic [15:0]   frame_full;
    frame_cls_t    cls;
    logic [CW-1:0] cnt_inc;

    function automatic frame_cls_t classify(input logic [15:0] f);
        if (f == 16'h0000)
            return EMPTY;
        else if ((f & (f - 16'd1)) == 16'h0000)
            return SINGLE;
        else
            return MULTI;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_DB) ? c : c + CW'(1);
    endfunction

    assign sample    = (dwell_q == DWELL_MAX);
    assign frame_end = sample && (col_q == 2'd3);
    assign cls       = classify(frame_full);
    assign cnt_inc   = sat_inc(cnt_q);

    // Frame with the current column's sample merged in, so the col-3 sample
    // is classified on the same edge that stores it.
    always_comb begin
        frame_full = frame_q;
        frame_full[{col_q, 2'b00} +: 4] = ~row_s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            dwell_q     <= '0;
            col_q       <= 2'd0;
            frame_q     <= 16'h0000;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= 16'h0000;
            onehot_q    <= 16'h0000;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            row_s1_q    <= kp.row_in;
            row_s2_q    <= row_s1_q;
            dwell_q     <= sample ? '0 : dwell_q + DW'(1);
            if (sample) begin
                col_q   <= col_q + 2'd1;
                frame_q <= frame_full;
            end
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            onehot_q    <= onehot_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        onehot_d    = onehot_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (cls == SINGLE) begin
                        cand_d  = frame_full;
                        cnt_d   = CNT_ONE;
                        state_d = PRESS_DB;
                        if (CNT_ONE == CNT_DB) begin
                            onehot_d    = frame_full;
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            state_d     = HELD;
                        end
                    end
                end
                PRESS_DB: begin
                    if (cls != SINGLE) begin
                        state_d = IDLE;
                    end else if (frame_full == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DB) begin
                            onehot_d    = cand_q;
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            state_d     = HELD;
                        end
                    end else begin
                        cand_d = frame_full;
                        cnt_d  = CNT_ONE;
                    end
                end
                HELD: begin
                    // Extra keys or roll-over while held never re-trigger.
                    if (cls == EMPTY) begin
                        cnt_d   = CNT_ONE;
                        state_d = REL_DB;
                        if (CNT_ONE == CNT_DB) begin
                            key_down_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end
                end
                REL_DB: begin
                    if (cls == EMPTY) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DB) begin
                            key_down_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign kp.col_out   = ~(4'b0001 << col_q);
    assign kp.onehot    = onehot_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 key matrix model.
module tb_keypad_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pressed = 16'h0000;
    logic [3:0]  exp_col;
    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    int          exp_pulses = 0;

    keypad_if kp();

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // Matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        kp.row_in = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!kp.col_out[c] && pressed[4*c+r])
                    kp.row_in[r] = 1'b0;
    end

    always begin
        @(posedge clk);
        #1;
        if (kp.key_valid === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n scan frames (16 clocks each) and stop at the negedge after the frame end.
    task automatic frames(input int n);
        repeat (n * 16) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_col", {28'h0, kp.col_out}, 32'hE);
        chk("rst_onehot", {16'h0, kp.onehot}, 32'h0);
        chk("rst_kv", {31'h0, kp.key_valid}, 32'h0);
        chk("rst_kd", {31'h0, kp.key_down}, 32'h0);
        rst = 1'b0;

        // Scan with no keys
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            chk("scan_col", {28'h0, kp.col_out}, {28'h0, exp_col});
        end
        chk("scan_pulses", pulses, 0);
        chk("scan_onehot", {16'h0, kp.onehot}, 32'h0);

        // Clean press: row 2 / col 1
        pressed = 16'h0040;
        frames(2);
        chk("press_early_kv", {31'h0, kp.key_valid}, 32'h0);
        chk("press_early_pulses", pulses, exp_pulses);
        frames(1);
        exp_pulses++;
        chk("press_kv", {31'h0, kp.key_valid}, 32'h1);
        chk("press_onehot", {16'h0, kp.onehot}, 32'h0040);
        chk("press_kd", {31'h0, kp.key_down}, 32'h1);
        frames(2);
        chk("press_pulses", pulses, exp_pulses);
        chk("press_kv_low", {31'h0, kp.key_valid}, 32'h0);

        // Release interrupted, then full release, then repress
        pressed = 16'h0000;
        frames(2);
        chk("rel2_kd", {31'h0, kp.key_down}, 32'h1);
        pressed = 16'h0040;
        frames(1);
        chk("rebounce_kd", {31'h0, kp.key_down}, 32'h1);
        chk("rebounce_pulses", pulses, exp_pulses);
        pressed = 16'h0000;
        frames(2);
        chk("rel_mid_kd", {31'h0, kp.key_down}, 32'h1);
        frames(1);
        chk("rel_kd", {31'h0, kp.key_down}, 32'h0);
        chk("rel_onehot", {16'h0, kp.onehot}, 32'h0040);
        pressed = 16'h0040;
        frames(2);
        chk("repress_early_kv", {31'h0, kp.key_valid}, 32'h0);
        frames(1);
        exp_pulses++;
        chk("repress_kv", {31'h0, kp.key_valid}, 32'h1);
        chk("repress_pulses", pulses, exp_pulses);

        // Bouncing press on bit 9
        pressed = 16'h0000;
        frames(3);
        chk("bounce_pre_kd", {31'h0, kp.key_down}, 32'h0);
        for (int b = 0; b < 2; b++) begin
            pressed = 16'h0200;
            frames(1);
            pressed = 16'h0000;
            frames(1);
        end
        chk("bounce_pulses", pulses, exp_pulses);
        chk("bounce_kd", {31'h0, kp.key_down}, 32'h0);
        pressed = 16'h0200;
        frames(2);
        chk("bounce_early_kv", {31'h0, kp.key_valid}, 32'h0);
        frames(1);
        exp_pulses++;
        chk("bounce_kv", {31'h0, kp.key_valid}, 32'h1);
        chk("bounce_onehot", {16'h0, kp.onehot}, 32'h0200);

        // Multi-key from IDLE, then roll-over while held
        pressed = 16'h0000;
        frames(3);
        pressed = 16'h0021;
        frames(4);
        chk("multi_pulses", pulses, exp_pulses);
        chk("multi_onehot", {16'h0, kp.onehot}, 32'h0200);
        chk("multi_kd", {31'h0, kp.key_down}, 32'h0);
        pressed = 16'h0000;
        frames(1);
        pressed = 16'h0001;
        frames(3);
        exp_pulses++;
        chk("single0_kv", {31'h0, kp.key_valid}, 32'h1);
        chk("single0_onehot", {16'h0, kp.onehot}, 32'h0001);
        pressed = 16'h0021;
        frames(2);
        chk("rollover_pulses", pulses, exp_pulses);
        chk("rollover_onehot", {16'h0, kp.onehot}, 32'h0001);
        chk("rollover_kd", {31'h0, kp.key_down}, 32'h1);

        // Reset during press debounce with cnt=2
        pressed = 16'h0000;
        frames(3);
        chk("pre_rst_kd", {31'h0, kp.key_down}, 32'h0);
        pressed = 16'h0040;
        frames(2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_col", {28'h0, kp.col_out}, 32'hE);
        chk("mid_rst_onehot", {16'h0, kp.onehot}, 32'h0);
        chk("mid_rst_kv", {31'h0, kp.key_valid}, 32'h0);
        chk("mid_rst_kd", {31'h0, kp.key_down}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        frames(2);
        chk("post_rst_early_kv", {31'h0, kp.key_valid}, 32'h0);
        chk("post_rst_early_pulses", pulses, exp_pulses);
        frames(1);
        exp_pulses++;
        chk("post_rst_kv", {31'h0, kp.key_valid}, 32'h1);
        chk("post_rst_onehot", {16'h0, kp.onehot}, 32'h0040);
        frames(1);
        chk("final_pulses", pulses, exp_pulses);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanner for the 4x4 matrix keypad: drives the column lines, samples the row lines, debounces, and produces the 16-bit one-hot key code consumed by the keypad encoder. It is the producer side of the one-hot key interface. The encoder holds its binary output while `onehot` is unchanged, so this block holds `onehot` at the last accepted key and signals each new press with a one-cycle `key_valid` pulse.

## Interface
- `SCAN_DIV`, 50000: clocks each column is driven low. Must be >= 4.
- `DEBOUNCE`, 4: consecutive identical scan frames required to accept a press or a release. Must be >= 1.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `row_in` input 4: keypad rows, active-low with external pull-ups. Asynchronous to `clk`.
- `col_out` output 4: keypad columns, active-low; exactly one bit is low at any time.
- `onehot` output 16: last accepted key; bit index = 4*col + row.
- `key_valid` output 1: one-cycle pulse when a new key is accepted.
- `key_down` output 1: level, high from acceptance until the release is debounced.

## Operation
- **Row synchronizer.** `row_in` passes through a 2-flop synchronizer, then is inverted, so that 1 means pressed.
- **Column scan.**
  - A dwell counter runs 0..SCAN_DIV-1. At wrap it advances the column index 0->1->2->3->0.
  - `col_out` equals ~(1 << col).
  - The synchronized rows are sampled at dwell == SCAN_DIV-1, which gives the settling time. They are written into frame bits [4*col+3 : 4*col].
- **Frame end.** The sample at col 3 completes a 16-bit frame (frame period 4*SCAN_DIV clocks). A frame is classified as:
  - EMPTY: zero bits set.
  - SINGLE: exactly one bit set.
  - MULTI: more than one bit set.
- **FSM.** Updates only at frame end; `stable_cnt` is saturating, `cand` is 16 bits.
  - IDLE:
    - SINGLE: cand=frame, cnt=1, go to PRESS_DB. If DEBOUNCE==1, accept immediately.
    - EMPTY or MULTI: stay.
  - PRESS_DB:
    - SINGLE equal to cand: cnt+1. When cnt reaches DEBOUNCE, accept and go to HELD.
    - SINGLE different from cand: cand=frame, cnt=1.
    - EMPTY or MULTI: go to IDLE.
  - Accept means: `onehot`<=cand, `key_valid`<=1 for one cycle, `key_down`<=1.
  - HELD:
    - EMPTY: cnt=1, go to REL_DB.
    - SINGLE or MULTI: stay. A second key or key roll-over never re-triggers.
  - REL_DB:
    - EMPTY: cnt+1. When cnt reaches DEBOUNCE, `key_down`<=0 and go to IDLE.
    - Any non-empty frame: go back to HELD.
- **Release behaviour.** `onehot` is never cleared on release; it changes only on acceptance. The same key pressed again is re-accepted and pulses `key_valid` again.

## Timing
- **Reset values.**
  - Column index 0, so `col_out`=4'b1110.
  - Dwell 0, frame 0, state IDLE, cnt 0, cand 0.
  - `onehot`=16'h0000, `key_valid`=0, `key_down`=0.
- **Reset mid-operation.** All of the above apply immediately (asynchronous). Scanning restarts from column 0 on the first clock after deassert.
- **Column change.** `col_out` changes on the clock edge where dwell wraps.
- **Input latency.** A row change reaches the sampled value after 2 clocks of synchronizer delay.
- **Frame-end update.** The state update, `key_valid` and `onehot` all register on the clock edge after the col-3 sample. `key_valid` and the new `onehot` appear in the same cycle.
- **Press latency.** A key held from before frame k starts is accepted at the end of frame k+DEBOUNCE-1.
- **Release latency.** `key_down` falls at the end of the DEBOUNCE-th consecutive empty frame.
- **Counter widths.**
  - Dwell counter: $clog2(SCAN_DIV) bits.
  - `stable_cnt`: $clog2(DEBOUNCE+1) bits, saturating.

## Test plan
- **Reset and scan.** Reset, no keys -> `col_out` cycles 1110, 1101, 1011, 0111, each for SCAN_DIV clocks. `onehot`=0, `key_valid` never pulses. Use SCAN_DIV=4, DEBOUNCE=3 in simulation.
- **Clean press.** Model the matrix: row 2 is pulled low while col 1 is low, held for 5 frames -> exactly one `key_valid` pulse, at the end of frame 3. `onehot`=16'h0040, `key_down`=1.
- **Bouncing press.** Key alternates present/absent on successive frames for 4 frames, then is stable -> no pulse during bounce. One pulse after 3 stable frames.
- **Release and repress.** After an accepted key, release:
  - 2 empty frames, then pressed again -> `key_down` stays 1 and there is no new pulse.
  - Then 3 empty frames -> `key_down`=0 and `onehot` still 16'h0040.
  - Repress -> new pulse.
- **Multi-key.** Press keys at bits 0 and 5 together from IDLE -> no acceptance. Press bit 0 first, accept it, then add bit 5 -> `onehot` stays 16'h0001 with no second pulse.
- **Reset mid-debounce.** Assert `rst` during PRESS_DB with cnt=2 -> outputs go to reset values immediately. After deassert, 3 further stable frames are needed before the pulse.
